// File: rtl/fsm_div_driver.sv
// Sequencer for fsm_div: takes one {a,b,c,d} packet, sends the operands as spaced
// valid pulses, then waits (with a watchdog) for the divider's result and reports it.
module fsm_div_driver #(
  parameter int GAP     = 1,
  parameter int TIMEOUT = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [15:0] ops_in,
  output logic        ready,
  output logic [3:0]  d_to_div,
  output logic        valid_to_div,
  input  logic        valid_from_div,
  input  logic [3:0]  d_from_div,
  input  logic        err_from_div,
  output logic [3:0]  result,
  output logic        error,
  output logic        timeout,
  output logic        done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SEND,
    S_GAP,
    S_WAIT,
    S_DONE
  } state_t;

  localparam logic [2:0] GAP_LAST  = 3'((GAP == 0) ? 0 : GAP - 1);
  localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

  state_t      state_q, state_d;
  logic [15:0] ops_q, ops_d;
  logic [1:0]  idx_q, idx_d;
  logic [2:0]  gap_cnt_q, gap_cnt_d;
  logic [7:0]  wait_cnt_q, wait_cnt_d;
  logic [3:0]  last_q, last_d;
  logic [3:0]  result_q, result_d;
  logic        error_q, error_d;
  logic        timeout_q, timeout_d;
  logic [3:0]  cur_op;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      ops_q      <= '0;
      idx_q      <= '0;
      gap_cnt_q  <= '0;
      wait_cnt_q <= '0;
      last_q     <= '0;
      result_q   <= '0;
      error_q    <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      ops_q      <= ops_d;
      idx_q      <= idx_d;
      gap_cnt_q  <= gap_cnt_d;
      wait_cnt_q <= wait_cnt_d;
      last_q     <= last_d;
      result_q   <= result_d;
      error_q    <= error_d;
      timeout_q  <= timeout_d;
    end
  end

  // Operand order on the wire is a, b, c, d (most significant nibble first).
  always_comb begin
    cur_op = ops_q[15:12];
    case (idx_q)
      2'd0: cur_op = ops_q[15:12];
      2'd1: cur_op = ops_q[11:8];
      2'd2: cur_op = ops_q[7:4];
      2'd3: cur_op = ops_q[3:0];
      default: cur_op = ops_q[15:12];
    endcase
  end

  always_comb begin
    state_d      = state_q;
    ops_d        = ops_q;
    idx_d        = idx_q;
    gap_cnt_d    = gap_cnt_q;
    wait_cnt_d   = wait_cnt_q;
    last_d       = last_q;
    result_d     = result_q;
    error_d      = error_q;
    timeout_d    = timeout_q;
    ready        = 1'b0;
    valid_to_div = 1'b0;
    done         = 1'b0;
    d_to_div     = last_q;

    case (state_q)
      S_IDLE: begin
        ready = 1'b1;
        if (start) begin
          ops_d     = ops_in;
          result_d  = '0;
          error_d   = 1'b0;
          timeout_d = 1'b0;
          idx_d     = '0;
          gap_cnt_d = '0;
          state_d   = S_SEND;
        end
      end

      S_SEND: begin
        valid_to_div = 1'b1;
        d_to_div     = cur_op;
        last_d       = cur_op;
        gap_cnt_d    = '0;
        if (idx_q == 2'd3) begin
          wait_cnt_d = '0;
          state_d    = S_WAIT;
        end else if (GAP == 0) begin
          idx_d = idx_q + 2'd1;
        end else begin
          state_d = S_GAP;
        end
      end

      S_GAP: begin
        if (gap_cnt_q == GAP_LAST) begin
          idx_d   = idx_q + 2'd1;
          state_d = S_SEND;
        end else if (gap_cnt_q != 3'd7) begin
          gap_cnt_d = gap_cnt_q + 3'd1;
        end
      end

      // A response in the last permitted cycle is still taken as a real result.
      S_WAIT: begin
        if (valid_from_div) begin
          result_d  = d_from_div;
          error_d   = err_from_div;
          timeout_d = 1'b0;
          state_d   = S_DONE;
        end else if (wait_cnt_q == WAIT_LAST) begin
          result_d  = '0;
          error_d   = 1'b1;
          timeout_d = 1'b1;
          state_d   = S_DONE;
        end else if (wait_cnt_q != 8'hFF) begin
          wait_cnt_d = wait_cnt_q + 8'd1;
        end
      end

      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  assign result  = result_q;
  assign error   = error_q;
  assign timeout = timeout_q;

endmodule

// File: tb/tb_fsm_div_driver.sv
// Bench for fsm_div_driver: two instances (GAP=1 and GAP=0), each paired with a
// behavioural fsm_div stand-in whose response latency is under bench control.
module tb_fsm_div_driver;

  localparam int TO = 32;

  logic        clk = 1'b0;
  logic        reset, start;
  logic [15:0] ops_in;

  logic       rdy [2];
  logic       vtd [2];
  logic       vfd [2];
  logic       efd [2];
  logic       dn  [2];
  logic       er  [2];
  logic       tm  [2];
  logic [3:0] dtd [2];
  logic [3:0] dfd [2];
  logic [3:0] rs  [2];

  int lat;
  bit mute, spur;
  int sel;
  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  // Divider behaviour: a/b - c - d in 4 bits, error (result 0) when a or b is zero.
  function automatic logic [4:0] fdiv(input logic [15:0] p);
    logic [3:0] a, b, c, d, q;
    a = p[15:12]; b = p[11:8]; c = p[7:4]; d = p[3:0];
    if (a == 4'd0 || b == 4'd0) return 5'h10;
    q = a / b;
    return {1'b0, 4'(q - c - d)};
  endfunction

  function automatic logic [3:0] nib(input logic [15:0] p, input int k);
    return 4'(p >> (12 - 4 * k));
  endfunction

  for (genvar g = 0; g < 2; g++) begin : gen
    localparam int GP = (g == 0) ? 1 : 0;
    logic [3:0] sop [4];
    logic [1:0] scnt;
    logic       sbusy, spv, fire;
    int         sleft;
    logic [4:0] m;

    fsm_div_driver #(.GAP(GP), .TIMEOUT(TO)) dut (
      .clk(clk), .reset(reset), .start(start), .ops_in(ops_in),
      .ready(rdy[g]), .d_to_div(dtd[g]), .valid_to_div(vtd[g]),
      .valid_from_div(vfd[g]), .d_from_div(dfd[g]), .err_from_div(efd[g]),
      .result(rs[g]), .error(er[g]), .timeout(tm[g]), .done(dn[g])
    );

    assign m      = fdiv({sop[0], sop[1], sop[2], sop[3]});
    assign fire   = sbusy && (sleft == 0);
    assign vfd[g] = fire || spv;
    assign dfd[g] = fire ? m[3:0] : ~m[3:0];
    assign efd[g] = fire ? m[4] : 1'b1;

    always @(posedge clk) begin
      if (reset) begin
        scnt  <= 2'd0;
        sbusy <= 1'b0;
        spv   <= 1'b0;
        sleft <= 0;
      end else begin
        spv <= 1'b0;
        if (sbusy) begin
          if (sleft == 0) sbusy <= 1'b0;
          else sleft <= sleft - 1;
        end
        if (vtd[g]) begin
          sop[scnt] <= dtd[g];
          scnt      <= scnt + 2'd1;
          if (scnt == 2'd1 && spur) spv <= 1'b1;
          if (scnt == 2'd3 && !mute) begin
            sbusy <= 1'b1;
            sleft <= lat;
          end
        end
      end
    end
  end

  int         npulse, done_cyc, extra_pulses;
  int         pcyc [8];
  logic [3:0] pval [8];
  bit         got_done, hold_ok, r_rdy, r_zero;
  logic [3:0] o_res, o_res_after;
  logic       o_err, o_tmo, o_rdy_after;

  // Drives one packet into the selected instance and records what it emits.
  task automatic run_txn(input logic [15:0] ops, input bit hold, input int abort_after);
    npulse = 0; got_done = 0; done_cyc = -1; hold_ok = 1; o_rdy_after = 0;
    extra_pulses = 0;
    for (int i = 0; i < 100 && !rdy[sel]; i++) @(negedge clk);
    ops_in = ops;
    start  = 1'b1;
    @(posedge clk);
    for (int c = 1; c <= 120; c++) begin
      @(negedge clk);
      if (hold) ops_in = 16'($urandom);
      else start = 1'b0;
      if (vtd[sel]) begin
        if (npulse < 8) begin
          pcyc[npulse] = c;
          pval[npulse] = dtd[sel];
        end
        npulse++;
      end else if (npulse > 0 && npulse < 4 && dtd[sel] !== pval[npulse-1]) begin
        hold_ok = 0;
      end
      if (dn[sel]) begin
        got_done = 1; done_cyc = c;
        o_res = rs[sel]; o_err = er[sel]; o_tmo = tm[sel];
        start = 1'b0;
        break;
      end
      if (abort_after > 0 && npulse == abort_after) begin
        start = 1'b0;
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reset  = 1'b0;
        r_rdy  = rdy[sel];
        r_zero = (dtd[sel] == 4'd0) && !vtd[sel] && (rs[sel] == 4'd0) &&
                 !er[sel] && !tm[sel] && !dn[sel];
        for (int j = 0; j < 20; j++) begin
          @(negedge clk);
          if (vtd[sel]) extra_pulses++;
        end
        return;
      end
    end
    start = 1'b0;
    if (got_done) begin
      @(negedge clk);
      o_rdy_after = rdy[sel];
      o_res_after = rs[sel];
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; start = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int g = 0; g < 2; g++) begin
      total++;
      if (rdy[g] !== 1'b1 || vtd[g] !== 1'b0 || dtd[g] !== 4'd0 || dn[g] !== 1'b0)
        $display("[TB] FAIL reset_ctl inst%0d: got rdy=%b v=%b d=%h done=%b, expected 1 0 0 0",
                 g, rdy[g], vtd[g], dtd[g], dn[g]);
      else passed++;
      total++;
      if (rs[g] !== 4'd0 || er[g] !== 1'b0 || tm[g] !== 1'b0)
        $display("[TB] FAIL reset_res inst%0d: got res=%h err=%b tmo=%b, expected 0 0 0",
                 g, rs[g], er[g], tm[g]);
      else passed++;
    end
    reset = 1'b0;
  endtask

  task automatic test_basic();
    sel = 0; lat = 2; mute = 0; spur = 0;
    run_txn(16'h8252, 0, 0);
    total++;
    if (npulse !== 4) $display("[TB] FAIL basic_npulse: got %0d expected 4", npulse);
    else passed++;
    for (int k = 0; k < 4; k++) begin
      total++;
      if (pcyc[k] !== 1 + 2 * k || pval[k] !== nib(16'h8252, k))
        $display("[TB] FAIL basic_pulse%0d: got cyc %0d val %h expected cyc %0d val %h",
                 k, pcyc[k], pval[k], 1 + 2 * k, nib(16'h8252, k));
      else passed++;
    end
    total++;
    if (done_cyc !== 8 + lat + 1) $display("[TB] FAIL basic_done_cyc: got %0d expected %0d", done_cyc, 8 + lat + 1);
    else passed++;
    total++;
    if ({o_res, o_err, o_tmo} !== {4'hD, 1'b0, 1'b0})
      $display("[TB] FAIL basic_result: got %h/%b/%b expected d/0/0", o_res, o_err, o_tmo);
    else passed++;
  endtask

  task automatic test_zero_result();
    sel = 0; lat = 0; mute = 0; spur = 1;
    run_txn(16'h9213, 0, 0);
    total++;
    if (!got_done || o_res !== 4'h0 || o_err !== 1'b0 || o_tmo !== 1'b0)
      $display("[TB] FAIL zero_result: got done=%b %h/%b/%b expected 1 0/0/0", got_done, o_res, o_err, o_tmo);
    else passed++;
    total++;
    if (o_rdy_after !== 1'b1 || o_res_after !== 4'h0)
      $display("[TB] FAIL zero_after: got rdy=%b res=%h expected 1 0", o_rdy_after, o_res_after);
    else passed++;
  endtask

  task automatic test_div_zero();
    logic [15:0] pk [2];
    pk[0] = 16'h5012; pk[1] = 16'h0432;
    sel = 0; mute = 0; spur = 0;
    for (int i = 0; i < 2; i++) begin
      lat = i * 3;
      run_txn(pk[i], 0, 0);
      total++;
      if (!got_done || o_err !== 1'b1 || o_tmo !== 1'b0)
        $display("[TB] FAIL div_zero %h: got done=%b err=%b tmo=%b expected 1 1 0", pk[i], got_done, o_err, o_tmo);
      else passed++;
    end
  endtask

  task automatic test_timeout();
    sel = 0; mute = 1; spur = 0; lat = 0;
    run_txn(16'h8252, 0, 0);
    total++;
    if (done_cyc !== 8 + TO) $display("[TB] FAIL timeout_cyc: got %0d expected %0d", done_cyc, 8 + TO);
    else passed++;
    total++;
    if ({o_res, o_err, o_tmo} !== {4'h0, 1'b1, 1'b1})
      $display("[TB] FAIL timeout_flags: got %h/%b/%b expected 0/1/1", o_res, o_err, o_tmo);
    else passed++;
    mute = 0; lat = TO - 1;
    run_txn(16'h8252, 0, 0);
    total++;
    if (done_cyc !== 8 + TO || {o_res, o_err, o_tmo} !== {4'hD, 1'b0, 1'b0})
      $display("[TB] FAIL last_cycle_wins: got cyc %0d %h/%b/%b expected cyc %0d d/0/0",
               done_cyc, o_res, o_err, o_tmo, 8 + TO);
    else passed++;
  endtask

  task automatic test_start_held();
    logic [15:0] pk;
    pk = 16'($urandom);
    sel = 0; mute = 0; spur = 0; lat = 1;
    run_txn(pk, 1, 0);
    total++;
    if (npulse !== 4 || !got_done) $display("[TB] FAIL held_npulse: got %0d done=%b expected 4 1", npulse, got_done);
    else passed++;
    for (int k = 0; k < 4; k++) begin
      total++;
      if (pval[k] !== nib(pk, k)) $display("[TB] FAIL held_op%0d: got %h expected %h", k, pval[k], nib(pk, k));
      else passed++;
    end
    total++;
    if (o_rdy_after !== 1'b1 || o_res !== fdiv(pk) >> 0 & 4'hF)
      $display("[TB] FAIL held_done: got rdy=%b res=%h expected 1 %h", o_rdy_after, o_res, fdiv(pk) & 5'hF);
    else passed++;
  endtask

  task automatic test_reset_mid(input int s);
    int g;
    sel = s; g = (s == 0) ? 1 : 0;
    do_reset();
    mute = 0; spur = 0; lat = 1;
    run_txn(16'h8252, 0, 2);
    total++;
    if (r_rdy !== 1'b1 || r_zero !== 1'b1)
      $display("[TB] FAIL mid_reset_state gap%0d: got rdy=%b zero=%b expected 1 1", g, r_rdy, r_zero);
    else passed++;
    total++;
    if (extra_pulses !== 0) $display("[TB] FAIL mid_reset_pulses gap%0d: got %0d expected 0", g, extra_pulses);
    else passed++;
    run_txn(16'h9213, 0, 0);
    total++;
    if (!got_done || npulse !== 4 || o_res !== 4'h0 || o_err !== 1'b0)
      $display("[TB] FAIL mid_reset_recover gap%0d: got done=%b n=%0d res=%h err=%b expected 1 4 0 0",
               g, got_done, npulse, o_res, o_err);
    else passed++;
  endtask

  task automatic test_gap0();
    sel = 1; mute = 0; spur = 0; lat = 3;
    do_reset();
    run_txn(16'h8252, 0, 0);
    for (int k = 0; k < 4; k++) begin
      total++;
      if (pcyc[k] !== 1 + k || pval[k] !== nib(16'h8252, k))
        $display("[TB] FAIL gap0_pulse%0d: got cyc %0d val %h expected cyc %0d val %h",
                 k, pcyc[k], pval[k], 1 + k, nib(16'h8252, k));
      else passed++;
    end
    total++;
    if (done_cyc !== 5 + lat + 1 || o_res !== 4'hD)
      $display("[TB] FAIL gap0_done: got cyc %0d res %h expected cyc %0d res d", done_cyc, o_res, 5 + lat + 1);
    else passed++;
  endtask

  task automatic test_random();
    logic [15:0] pk;
    logic [4:0]  ex;
    int          gp, w, ecyc;
    bit          tmo_exp;
    for (int s = 0; s < 2; s++) begin
      sel = s; gp = (s == 0) ? 1 : 0;
      do_reset();
      for (int i = 0; i < 12; i++) begin
        pk   = 16'($urandom);
        lat  = $urandom_range(0, 40);
        mute = ($urandom_range(0, 7) == 0);
        spur = $urandom_range(0, 1);
        run_txn(pk, 0, 0);
        w       = 5 + 3 * gp;
        tmo_exp = mute || (lat >= TO);
        ecyc    = tmo_exp ? w + TO : w + lat + 1;
        ex      = tmo_exp ? 5'h10 : fdiv(pk);
        total++;
        if (npulse !== 4 || !hold_ok) $display("[TB] FAIL rnd_pulses g%0d #%0d: got n=%0d hold=%b expected 4 1", gp, i, npulse, hold_ok);
        else passed++;
        for (int k = 0; k < 4; k++) begin
          total++;
          if (pcyc[k] !== 1 + k * (gp + 1) || pval[k] !== nib(pk, k))
            $display("[TB] FAIL rnd_pulse%0d g%0d #%0d: got cyc %0d val %h expected cyc %0d val %h",
                     k, gp, i, pcyc[k], pval[k], 1 + k * (gp + 1), nib(pk, k));
          else passed++;
        end
        total++;
        if (done_cyc !== ecyc) $display("[TB] FAIL rnd_done_cyc g%0d #%0d: got %0d expected %0d", gp, i, done_cyc, ecyc);
        else passed++;
        total++;
        if ({o_err, o_res, o_tmo} !== {ex, tmo_exp})
          $display("[TB] FAIL rnd_result g%0d #%0d: got %b/%h/%b expected %b/%h/%b",
                   gp, i, o_err, o_res, o_tmo, ex[4], ex[3:0], tmo_exp);
        else passed++;
      end
    end
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; ops_in = '0;
    lat = 0; mute = 0; spur = 0; sel = 0;
    test_reset();
    test_basic();
    test_zero_result();
    test_div_zero();
    test_timeout();
    test_start_held();
    test_reset_mid(0);
    test_reset_mid(1);
    test_gap0();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/fsm_div_driver.md
Name: fsm_div_driver

Overview:
Upstream/downstream companion of fsm_div. Accepts one parallel operand packet {a,b,c,d} with a start/ready handshake. Serialises the four operands onto fsm_div's d_in/valid_in as single-cycle pulses separated by idle gaps, then waits for fsm_div's valid_out and captures d_out/error_out. Presents the captured result with a one-cycle done pulse and a watchdog timeout, so upper levels never sequence fsm_div by hand.

Parameters:
GAP, 1, idle cycles (valid_to_div=0) between consecutive operand pulses; legal 0..7.
TIMEOUT, 32, max cycles spent in WAIT before giving up; legal 2..255.

Ports:
clk  input  1  system clock, all logic on rising edge
reset  input  1  synchronous, active-high reset
start  input  1  request; accepted only when ready=1
ops_in  input  16  packet: a=[15:12], b=[11:8], c=[7:4], d=[3:0]
ready  output  1  high only in IDLE
d_to_div  output  4  operand to fsm_div d_in
valid_to_div  output  1  to fsm_div valid_in, one-cycle pulse per operand
valid_from_div  input  1  from fsm_div valid_out
d_from_div  input  4  from fsm_div d_out
err_from_div  input  1  from fsm_div error_out
result  output  4  captured result (two's complement)
error  output  1  captured error flag (div-by-zero or timeout)
timeout  output  1  set when WAIT expired without valid_from_div
done  output  1  one-cycle pulse when result/error/timeout are valid

Behaviour:
- Reset (sync, high): state=IDLE; ready=1; d_to_div=0, valid_to_div=0, result=0, error=0, timeout=0, done=0; counters and idx=0. Reset mid-operation aborts immediately, and no further pulses are issued.
- States: IDLE, SEND, GAP, WAIT, DONE.
- IDLE: ready=1. start=1 latches ops_in, clears result/error/timeout, sets idx=0, goes to SEND. start=0 stays in IDLE.
- start in any other state is ignored and not queued. ops_in is only sampled on accept.
- SEND (one cycle): valid_to_div=1, d_to_div=operand[idx], idx order a,b,c,d.
  - If idx=3, go to WAIT.
  - Else if GAP=0, idx+1 and stay in SEND (back-to-back pulses).
  - Else go to GAP.
- GAP: valid_to_div=0; d_to_div holds the last operand. Stays GAP cycles, then idx+1 and SEND.
- Pulse timing (accept cycle = 0): pulse k (k=0..3) at cycle 1+k*(GAP+1). GAP=1 gives pulses at 1,3,5,7; WAIT starts at cycle 8.
- WAIT: valid_to_div=0; wait counter starts at 0 and increments each cycle.
  - valid_from_div=1 (level) in a WAIT cycle: capture result=d_from_div, error=err_from_div, timeout=0; go to DONE.
  - No valid_from_div within TIMEOUT WAIT cycles: result=0, error=1, timeout=1; go to DONE.
  - valid_from_div in the final WAIT cycle wins over the timeout.
- valid_from_div outside WAIT is ignored.
- DONE (one cycle): done=1, then IDLE. result/error/timeout hold until the next accepted start.
- Widths: the GAP counter is 3 bits and the wait counter is 8 bits; both saturate safely. No arithmetic on data; results pass through unchanged.

Test Plan:
- Reset, then start with ops_in=16'h8252 (8/2-5-2) into a real fsm_div -> pulses carry 8,2,5,2 at cycles 1,3,5,7; done with result=4'hD (-3), error=0, timeout=0.
- ops_in=16'h9213 (9/2-1-3) -> result=0, error=0; ready returns to 1 the cycle after done.
- ops_in=16'h5012 (b=0) and 16'h0432 (a=0) -> done with error=1, timeout=0.
- Stub fsm_div that never asserts valid_out, TIMEOUT=32 -> done exactly 32 cycles after WAIT entry; result=0, error=1, timeout=1.
- start held high through the whole transaction with changing ops_in -> exactly one transaction; operands equal the packet latched at accept.
- Reset asserted between pulse 2 and pulse 3 -> no further valid_to_div pulses, all outputs 0, ready=1 the cycle after reset; a following transaction completes correctly. Also rerun with GAP=0 to check back-to-back pulses at cycles 1..4.
